div8by4_seq: RTL and testbench

- Sequential unsigned divider; the inverse of the team's 4-bit decomposed multipliers.
- Takes a 2N-bit dividend, as produced by an N×N multiplier, and an N-bit divisor.
- Returns an N-bit quotient and an N-bit remainder.
- Restoring algorithm, one quotient bit per clock, with a valid/ready handshake on both sides.
- Sits downstream of the multiplier array, for round-trip checking and for datapaths that need division.

---
 rtl/div8by4_seq.sv | 187 ++++++++++++++++++
 tb/tb_div8by4_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div8by4_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder, one bit per clock.
// Optional `DIV_SELFCHECK_EN adds a q*d+r == dividend round-trip check (chk_err).
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | one restoring step per clock, N steps
// DONE  | out_valid=1, result held until out_ready
module div8by4_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf,
    output logic           chk_err
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  shr_q, shr_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic [N:0]    t;
    logic          t_ge;
    logic [N-1:0]  rem_step;
    logic [N-1:0]  quo_step;
    logic          accept;
    logic          handoff;
    logic          last_step;

    // t is N+1 bits wide so the shifted-in bit never truncates before the compare.
    always_comb begin
        t        = {rem_q, shr_q[N-1]};
        t_ge     = (t >= {1'b0, dvs_q});
        rem_step = t_ge ? N'(t - {1'b0, dvs_q}) : t[N-1:0];
        quo_step = {quo_q[N-2:0], t_ge};
    end

    assign accept    = (state_q == IDLE) && in_valid;
    assign handoff   = (state_q == DONE) && out_ready;
    assign last_step = (state_q == CALC) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shr_d   = shr_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    quo_d = '1;
                    rem_d = dividend[N-1:0];
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = dividend[2*N-1:N];
                        shr_d   = dividend[N-1:0];
                        quo_d   = '0;
                        cnt_d   = CW'(N - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                shr_d = {shr_q[N-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            shr_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shr_q   <= shr_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = out_valid ? quo_q : '0;
    assign remainder = out_valid ? rem_q : '0;
    assign div_zero  = dz_q;
    assign ovf       = ovf_q;

`ifdef DIV_SELFCHECK_EN
    localparam int H = N / 2;

    logic [2*N-1:0] dvd_q;
    logic [2*N-1:0] prod;
    logic [N-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
    logic           chk_q, chk_d;

    // Rebuild q*d from four half-width partial products, same decomposition as the multiplier array.
    always_comb begin
        pp_ll = N'(quo_step[H-1:0]) * N'(dvs_q[H-1:0]);
        pp_lh = N'(quo_step[H-1:0]) * N'(dvs_q[N-1:H]);
        pp_hl = N'(quo_step[N-1:H]) * N'(dvs_q[H-1:0]);
        pp_hh = N'(quo_step[N-1:H]) * N'(dvs_q[N-1:H]);
        prod  = (2*N)'(pp_ll)
              + ((2*N)'(pp_lh) << H)
              + ((2*N)'(pp_hl) << H)
              + ((2*N)'(pp_hh) << N)
              + (2*N)'(rem_step);
        chk_d = chk_q;
        if (accept || handoff) begin
            chk_d = 1'b0;
        end else if (last_step) begin
            chk_d = (prod != dvd_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (accept) begin
                dvd_q <= dividend;
            end
            chk_q <= chk_d;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div8by4_seq.sv
// Scoreboard bench for div8by4_seq: driver pushes hand-computed results, a negedge monitor pops and compares.
module tb_div8by4_seq;
    localparam int N = 4;
    localparam int P = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       ovf;
    logic       chk_err;

    always #(P/2) clk = ~clk;

    div8by4_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf),
        .chk_err   (chk_err)
    );

    typedef struct {
        int     q;
        int     r;
        int     dz;
        int     ov;
        int     lat;
        longint t_acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   prev_v = 1'b0;
    bit   expect_idle = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Normal results appear N edges after the accept edge; exceptions go straight to DONE on the accept edge.
    task automatic send(int dvd, int dvs, int q, int r, int dz, int ov);
        int   n;
        exp_t x;
        n = 0;
        @(negedge clk);
        dividend = 8'(dvd);
        divisor  = 4'(dvs);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", int'(in_ready), 1);
        chk("no_overlap", sb.size(), 0);
        x.q     = q;
        x.r     = r;
        x.dz    = dz;
        x.ov    = ov;
        x.lat   = (dz != 0 || ov != 0) ? 0 : N;
        x.t_acc = longint'($time) + P/2;
        sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = ~dividend;
        divisor  = ~divisor;
        if (x.lat == N) begin
            for (int i = 0; i < N; i++) begin
                chk("calc_in_ready", int'(in_ready), 0);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_div_zero", int'(div_zero), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_chk_err", int'(chk_err), 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_v      = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("post_handoff_valid", int'(out_valid), 0);
                chk("post_handoff_ready", int'(in_ready), 1);
                expect_idle = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = sb[0];
                    if (!prev_v) begin
                        chk("latency", int'((longint'($time) - 7 - e.t_acc) / P), e.lat);
                    end
                    chk("quotient", int'(quotient), e.q);
                    chk("remainder", int'(remainder), e.r);
                    chk("div_zero", int'(div_zero), e.dz);
                    chk("ovf", int'(ovf), e.ov);
                    chk("chk_err", int'(chk_err), 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        expect_idle = 1'b1;
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        int n;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(143, 13, 11, 0, 0, 0);
        send(100, 7, 14, 2, 0, 0);
        send(225, 15, 15, 0, 0, 0);
        send(8'h55, 0, 15, 5, 1, 0);
        send(8'hF0, 3, 15, 0, 0, 1);
        send(8'h30, 3, 15, 0, 0, 1);
        send(8'h2F, 3, 15, 2, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(127, 8, 15, 7, 0, 0);
        send(8'h70, 8, 14, 0, 0, 0);
        wait_idle();

        out_ready = 1'b0;
        send(200, 15, 13, 5, 0, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_seen", int'(out_valid), 1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        wait_idle();

        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(9, 3, 3, 0, 0, 0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
